// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled 8N1 receiver and its FIFO.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] MID_TICK   = 4'd7;
   localparam logic [3:0] LAST_TICK  = 4'd15;
   localparam int         DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push into a full FIFO is only
// accepted when a real pop happens on the same clk.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 wr_drop,
   output logic                 empty,
   output logic                 half_full,
   output logic                 full
);

   localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_HALF = (ADDR_W+1)'(DEPTH / 2);
   localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [DATA_BITS-1:0] mem_d [DEPTH];
   logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]      count_q, count_d;
   logic                 rd_ok_s;
   logic                 wr_ok_s;

   // Accept/drop decisions, pointer and occupancy updates.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rd_ok_s  = rd_en && (count_q != CNT_ZERO);
      wr_ok_s  = wr_en && ((count_q != CNT_FULL) || rd_ok_s);
      wr_drop  = wr_en && !wr_ok_s;
      if (wr_ok_s) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_ok_s, rd_ok_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers and count; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_BITS{1'b0}};
         end
         wr_ptr_q <= {ADDR_W{1'b0}};
         rd_ptr_q <= {ADDR_W{1'b0}};
         count_q  <= CNT_ZERO;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign empty     = (count_q == CNT_ZERO);
   assign full      = (count_q == CNT_FULL);
   assign half_full = (count_q >= CNT_HALF);

endmodule

// File: rtl/uart_rx16.sv
// 8N1 serial receiver: RxD synchroniser, 16x oversampling frame FSM,
// receive FIFO and sticky framing/overrun flags.
module uart_rx16
   import uart_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_16_x_baud,
   input  logic       serial_in,
   input  logic       buffer_read,
   input  logic       err_clear,
   output logic [7:0] data_out,
   output logic       buffer_data_present,
   output logic       buffer_half_full,
   output logic       buffer_full,
   output logic       framing_error,
   output logic       overrun
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   rx_state_t              state_q, state_d;
   logic [3:0]             tick_q, tick_d;
   logic [2:0]             bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   framing_q, framing_d;
   logic                   overrun_q, overrun_d;
   logic                   rx_s;
   logic                   push_s;
   logic                   frame_err_s;
   logic                   fifo_drop_s;
   logic                   fifo_empty_s;

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Frame recovery; every decision is taken on a baud strobe only.
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], serial_in};
      state_d     = state_q;
      tick_d      = tick_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      push_s      = 1'b0;
      frame_err_s = 1'b0;
      if (en_16_x_baud) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d = ST_START;
                  tick_d  = 4'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_START: begin
               if (tick_q == MID_TICK) begin
                  // Re-check the line mid start bit to reject short glitches.
                  if (!rx_s) begin
                     state_d = ST_DATA;
                     tick_d  = 4'd0;
                     bit_d   = 3'd0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
            ST_DATA: begin
               tick_d = tick_q + 4'd1;
               if (tick_q == LAST_TICK) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_q == LAST_BIT) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  shift_d = shift_q;
               end
            end
            ST_STOP: begin
               tick_d = tick_q + 4'd1;
               if (tick_q == LAST_TICK) begin
                  if (rx_s) begin
                     push_s  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     frame_err_s = 1'b1;
                     state_d     = ST_BREAK;
                  end
               end else begin
                  state_d = ST_STOP;
               end
            end
            ST_BREAK: begin
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BREAK;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Sticky error flags; a new error on the clear clk keeps the flag set.
   always_comb begin
      if (frame_err_s) begin
         framing_d = 1'b1;
      end else if (err_clear) begin
         framing_d = 1'b0;
      end else begin
         framing_d = framing_q;
      end
      if (push_s && fifo_drop_s) begin
         overrun_d = 1'b1;
      end else if (err_clear) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Synchroniser, FSM and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= {SYNC_STAGES{1'b1}};
         state_q   <= ST_IDLE;
         tick_q    <= 4'd0;
         bit_q     <= 3'd0;
         shift_q   <= {DATA_BITS{1'b0}};
         framing_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         framing_q <= framing_d;
         overrun_q <= overrun_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (push_s),
      .wr_data   (shift_q),
      .rd_en     (buffer_read),
      .rd_data   (data_out),
      .wr_drop   (fifo_drop_s),
      .empty     (fifo_empty_s),
      .half_full (buffer_half_full),
      .full      (buffer_full)
   );

   assign buffer_data_present = !fifo_empty_s;
   assign framing_error       = framing_q;
   assign overrun             = overrun_q;

endmodule
